// File: rtl/mandel_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mandel_scheduler
// Description : Frame scheduler for two Mandelbrot iteration engines. Hands
//               pixel coordinates to the engines alternately in raster order.
//               Collects their iteration counts in the same order and emits
//               them as grey-scale pixels on an AXI4-Stream style output.
// Revision    : 1.0 - initial release
// ============================================================================
module mandel_scheduler #(
  parameter int X_SIZE = 480,
  parameter int Y_SIZE = 480,
  parameter int CW     = 10,
  parameter int IW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          continuous,
  output logic          busy,
  output logic          frame_done,
  output logic          req0_valid,
  input  logic          req0_ready,
  output logic [CW-1:0] req0_x,
  output logic [CW-1:0] req0_y,
  output logic          req1_valid,
  input  logic          req1_ready,
  output logic [CW-1:0] req1_x,
  output logic [CW-1:0] req1_y,
  input  logic          res0_valid,
  output logic          res0_ready,
  input  logic [IW-1:0] res0_iter,
  input  logic          res1_valid,
  output logic          res1_ready,
  input  logic [IW-1:0] res1_iter,
  output logic          out_stream_tvalid,
  input  logic          out_stream_tready,
  output logic [31:0]   out_stream_tdata,
  output logic          out_stream_tuser,
  output logic          out_stream_tlast
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CW-1:0] X_LAST = CW'(X_SIZE - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(Y_SIZE - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   dx_q, dx_d, dy_q, dy_d;
  logic [CW-1:0]   ox_q, ox_d, oy_q, oy_d;
  logic            d_sel_q, d_sel_d, o_sel_q, o_sel_d;
  logic            tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
  logic            eof_q, eof_d;     // word in the output register is the frame's last pixel
  logic [31:0]     tdata_q, tdata_d;

  logic            dispatch_hs, res_take, res_hs, out_hs, frame_end;
  logic [IW-1:0]   sel_iter;
  logic [7:0]      grey;

  assign dispatch_hs = (state_q == S_RUN) && (d_sel_q ? req1_ready : req0_ready);
  // A result may be taken whenever the output register is empty or being emptied.
  assign res_take    = (state_q != S_IDLE) && (!tvalid_q || out_stream_tready);
  assign res_hs      = res_take && (o_sel_q ? res1_valid : res0_valid);
  assign out_hs      = tvalid_q && out_stream_tready;
  assign frame_end   = out_hs && eof_q;
  assign sel_iter    = o_sel_q ? res1_iter : res0_iter;

  assign busy              = (state_q != S_IDLE);
  assign frame_done        = frame_end;
  assign req0_valid        = (state_q == S_RUN) && !d_sel_q;
  assign req1_valid        = (state_q == S_RUN) &&  d_sel_q;
  assign req0_x            = dx_q;
  assign req0_y            = dy_q;
  assign req1_x            = dx_q;
  assign req1_y            = dy_q;
  assign res0_ready        = res_take && !o_sel_q;
  assign res1_ready        = res_take &&  o_sel_q;
  assign out_stream_tvalid = tvalid_q;
  assign out_stream_tdata  = tdata_q;
  assign out_stream_tuser  = tuser_q;
  assign out_stream_tlast  = tlast_q;

  // Next-state logic for the FSM, dispatch/output counters and output register.
  always_comb begin
    state_d  = state_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    d_sel_d  = d_sel_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    o_sel_d  = o_sel_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    eof_d    = eof_q;
    grey     = '0;
    grey[IW-1:0] = sel_iter;

    if (out_hs) tvalid_d = 1'b0;

    // A result refills the output register; overrides the clear above.
    if (res_hs) begin
      tvalid_d = 1'b1;
      tdata_d  = {8'h00, grey, grey, grey};
      tuser_d  = (ox_q == '0) && (oy_q == '0);
      tlast_d  = (ox_q == X_LAST);
      eof_d    = (ox_q == X_LAST) && (oy_q == Y_LAST);
      o_sel_d  = ~o_sel_q;
      if (ox_q == X_LAST) begin
        ox_d = '0;
        oy_d = (oy_q == Y_LAST) ? '0 : oy_q + 1'b1;
      end else begin
        ox_d = ox_q + 1'b1;
      end
    end

    if (dispatch_hs) begin
      d_sel_d = ~d_sel_q;
      if (dx_q == X_LAST) begin
        dx_d = '0;
        if (dy_q == Y_LAST) begin
          dy_d    = '0;
          state_d = S_DRAIN;
        end else begin
          dy_d = dy_q + 1'b1;
        end
      end else begin
        dx_d = dx_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start || continuous) begin
          state_d = S_RUN;
          dx_d = '0; dy_d = '0; d_sel_d = 1'b0;
          ox_d = '0; oy_d = '0; o_sel_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (frame_end) begin
          state_d = continuous ? S_RUN : S_IDLE;
          dx_d = '0; dy_d = '0; d_sel_d = 1'b0;
          ox_d = '0; oy_d = '0; o_sel_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dx_q     <= '0;
      dy_q     <= '0;
      d_sel_q  <= 1'b0;
      ox_q     <= '0;
      oy_q     <= '0;
      o_sel_q  <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      eof_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      d_sel_q  <= d_sel_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      o_sel_q  <= o_sel_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      eof_q    <= eof_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/mandel_scheduler.md
MANDEL_SCHEDULER -- requirements
Module: mandel_scheduler

Interface
REQ-001 Parameter X_SIZE, default 480, pixels per line.
REQ-002 Parameter Y_SIZE, default 480, lines per frame.
REQ-003 Parameter CW, default 10, coordinate width; 2^CW SHALL be >= max(X_SIZE, Y_SIZE).
REQ-004 Parameter IW, default 8, iteration-count width; IW SHALL be <= 8.
REQ-005 One clock and one reset; the reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
REQ-009 continuous  in  1  when 1, a new frame begins automatically after each frame.
REQ-010 busy  out  1  high whenever the state is not IDLE.
REQ-011 frame_done  out  1  one-cycle pulse on the last pixel's output handshake.
REQ-012 req0_valid/req1_valid  out  1  coordinate request to engine 0/1.
REQ-013 req0_ready/req1_ready  in  1  engine 0/1 accepts a request.
REQ-014 req0_x, req0_y, req1_x, req1_y  out  CW  pixel coordinates.
REQ-015 res0_valid/res1_valid  in  1  engine 0/1 result available.
REQ-016 res0_ready/res1_ready  out  1  scheduler accepts the result.
REQ-017 res0_iter/res1_iter  in  IW  iteration count.
REQ-018 out_stream_tvalid  out  1; out_stream_tready  in  1; out_stream_tdata  out  32; out_stream_tuser  out  1 (SOF); out_stream_tlast  out  1 (EOL).

Function
REQ-019 States: IDLE, RUN, DRAIN.
REQ-020 IDLE->RUN on start=1 or continuous=1; all counters and selectors are cleared on entry.
REQ-021 Dispatch counters dx, dy walk raster order; pixel index k goes to engine (k mod 2); d_sel starts at 0 and toggles on each dispatch handshake.
REQ-022 In RUN, req{d_sel}_valid SHALL be 1 and the other engine's req_valid SHALL be 0; in IDLE and DRAIN both are 0.
REQ-023 Once asserted, req_valid, req_x and req_y SHALL hold stable until req_ready=1.
REQ-024 Each dispatch handshake advances dx; at dx=X_SIZE-1, dx wraps to 0 and dy increments.
REQ-025 RUN->DRAIN on the dispatch handshake of pixel (X_SIZE-1, Y_SIZE-1).
REQ-026 Output counters ox, oy and o_sel track raster order independently of dispatch; o_sel toggles on each result handshake.
REQ-027 res{o_sel}_ready = (state != IDLE) AND (out_stream_tvalid=0 OR out_stream_tready=1); the other engine's res_ready SHALL be 0, so results are always emitted in raster order regardless of engine latency.
REQ-028 A result handshake loads the output register on the same edge:
- tdata = {8'h00, g, g, g}, where g = iter zero-extended to 8 bits
- tuser = (ox=0 AND oy=0)
- tlast = (ox=X_SIZE-1)
- tvalid = 1
REQ-029 The output register SHALL hold all fields stable while tvalid=1 and tready=0; tvalid clears on a handshake that is not refilled in the same cycle.
REQ-030 Latency: result handshake to tvalid is exactly 1 cycle; full throughput is 1 word per cycle.
REQ-031 On the output handshake of the last pixel:
- frame_done SHALL pulse for one cycle
- DRAIN->IDLE if continuous=0
- DRAIN->RUN with counters cleared if continuous=1; the first dispatch occurs the following cycle
REQ-032 start while busy=1 SHALL be ignored; continuous dropping mid-frame SHALL complete the current frame only.
REQ-033 Simultaneous output handshake and result handshake in one cycle SHALL replace the register contents with no bubble.

Reset
REQ-034 On rst=1, on the next edge:
- state = IDLE
- all counters and selectors = 0
- busy, frame_done, req*_valid, res*_ready, out_stream_tvalid, tuser, tlast = 0
- tdata = 0
REQ-035 rst mid-frame SHALL abort the frame and discard in-flight results; a later start SHALL produce a complete frame beginning with SOF.

Verification
REQ-036 X_SIZE=4, Y_SIZE=2, engines with fixed 3-cycle latency returning iter=x+4y, tready=1, start pulse -> exactly 8 words with g=0..7 in order, tuser on word 0 only, tlast on words 3 and 7, one frame_done pulse, busy returns to 0.
REQ-037 Same setup with PRBS 50% tready -> 8 words with none dropped or duplicated; tdata/tuser/tlast stable through every stall.
REQ-038 Engine 1 latency 20, engine 0 latency 2 -> engine 0 receives x=0,2,0,2 and engine 1 receives x=1,3,1,3; output remains in raster order.
REQ-039 continuous=1 -> frames back-to-back; SOF on the first word of each frame, tlast every 4th word, frame_done every 8th word.
REQ-040 rst asserted after 5 output words -> next cycle all valids 0 and busy 0; a subsequent start yields a full 8-word frame beginning with SOF.
REQ-041 start pulse during RUN -> no effect on counters; the frame still contains exactly 8 words.
